// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

    // Write-section masks carried on wsect; all-zero means a read.
    localparam logic [2:0] SECT_NONE    = 3'b000;
    localparam logic [2:0] SECT_BYTE0   = 3'b001;
    localparam logic [2:0] SECT_BYTE1   = 3'b010;
    localparam logic [2:0] SECT_HALF_HI = 3'b100;
    localparam logic [2:0] SECT_WORD    = 3'b111;

    // Port ownership: IDLE arbitrates round-robin, OWNn is a held lock.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_state_e;

    function automatic logic is_read(input logic [2:0] wsect);
        return wsect == SECT_NONE;
    endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin pick: one-hot grant from two requests and last winner.
// Latency: combinational.
// Backpressure: none; a master that is not picked simply keeps requesting.
// Ports: req0/req1 requests, last (1 = master 1 won last time), gnt one-hot.
module mem_arb_rr_pick (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            // Tie goes to whoever did not win the previous arbitration.
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = {req1, req0};
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory/MMIO data port between two masters, round-robin,
// with optional grant locking (MEM_ARB_LOCK_EN) and read-data return tagging.
// Latency: grant is combinational; read data returns one cycle after accept.
// Backpressure: ungranted masters hold req/addr/wdata/wsect until gnt.
// Ports: clk24/rst (async, active-high); per master mN_req/lock/addr/wdata/
//        wsect in, mN_gnt/rvalid/rdata out; slave s_addr/wdata/wsect out,
//        s_rdata in. Macro MEM_ARB_LOCK_EN enables locked ownership.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic        clk24,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_wsect,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_wsect,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [2:0]  s_wsect,
    input  logic [31:0] s_rdata
);

    own_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       rv0_q, rv0_d;
    logic       rv1_q, rv1_d;
    logic [1:0] pick;

`ifdef MEM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0] lock_cnt_inc;
`else
    // Lock inputs and the lock limit have no effect in this build.
    logic unused_lock;
    assign unused_lock = ^{m0_lock, m1_lock, LOCK_MAX[0]};
`endif

    mem_arb_rr_pick u_pick (
        .req0 (m0_req),
        .req1 (m1_req),
        .last (last_q),
        .gnt  (pick)
    );

    // Grant decision; held off entirely while reset is asserted.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:    {m1_gnt, m0_gnt} = pick;
                OWN0:    m0_gnt = m0_req;
                OWN1:    m1_gnt = m1_req;
                default: ;
            endcase
        end
    end

    // Slave mux: an idle port presents m0's address with nothing written.
    always_comb begin
        s_addr  = m0_addr;
        s_wdata = '0;
        s_wsect = SECT_NONE;
        if (m1_gnt) begin
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_wsect = m1_wsect;
        end else if (m0_gnt) begin
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_wsect = m0_wsect;
        end
    end

    // Next-state: round-robin history, ownership and read tags.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        rv0_d   = m0_gnt && m0_req && is_read(m0_wsect);
        rv1_d   = m1_gnt && m1_req && is_read(m1_wsect);
`ifdef MEM_ARB_LOCK_EN
        lock_cnt_d   = lock_cnt_q;
        // Count includes the access being granted this cycle.
        lock_cnt_inc = lock_cnt_q + CNT_W'(1);
`endif
        case (state_q)
            IDLE: begin
                if (m0_gnt) last_d = 1'b0;
                if (m1_gnt) last_d = 1'b1;
`ifdef MEM_ARB_LOCK_EN
                // With LOCK_MAX of 1 the first grant already exhausts the lock.
                if (LOCK_MAX > 1) begin
                    if (m0_gnt && m0_lock) begin
                        state_d    = OWN0;
                        lock_cnt_d = CNT_W'(1);
                    end else if (m1_gnt && m1_lock) begin
                        state_d    = OWN1;
                        lock_cnt_d = CNT_W'(1);
                    end
                end
`endif
            end
`ifdef MEM_ARB_LOCK_EN
            OWN0: begin
                if (!m0_req || !m0_lock || lock_cnt_inc == CNT_W'(LOCK_MAX)) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_inc;
                end
            end
            OWN1: begin
                if (!m1_req || !m1_lock || lock_cnt_inc == CNT_W'(LOCK_MAX)) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_inc;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            rv0_q      <= 1'b0;
            rv1_q      <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
            lock_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            rv0_q      <= rv0_d;
            rv1_q      <= rv1_d;
`ifdef MEM_ARB_LOCK_EN
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

    assign m0_rvalid = rv0_q;
    assign m1_rvalid = rv1_q;
    assign m0_rdata  = rv0_q ? s_rdata : '0;
    assign m1_rdata  = rv1_q ? s_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-cycle vector table with expected grants, plus a
// read-return scoreboard fed by the bench's own memory model.
module tb_mem_arbiter;

    localparam int LOCK_MAX = 4;

    logic        clk24 = 1'b0;
    logic        rst   = 1'b1;
    logic        m0_req = 1'b0, m0_lock = 1'b0, m1_req = 1'b0, m1_lock = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [2:0]  m0_wsect = '0, m1_wsect = '0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [2:0]  s_wsect;
    logic [31:0] s_rdata = '0;

    mem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk24(clk24), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wsect(m0_wsect), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wsect(m1_wsect), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wsect(s_wsect), .s_rdata(s_rdata)
    );

    always #5 clk24 = ~clk24;

    // Memory model: one-cycle read latency from the presented address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clk24) s_rdata <= mem_word(s_addr);

    typedef struct {
        logic        rst;
        logic        r0, l0;
        logic [31:0] a0;
        logic [2:0]  ws0;
        logic        r1, l1;
        logic [31:0] a1;
        logic [2:0]  ws1;
        logic        eg0, eg1;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } rd_t;

    vec_t vecs[$];
    rd_t  sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic rst_i, input logic r0, input logic l0, input logic [31:0] a0,
                       input logic [2:0] ws0, input logic r1, input logic l1, input logic [31:0] a1,
                       input logic [2:0] ws1, input logic eg0, input logic eg1);
        vec_t v;
        v.rst = rst_i; v.r0 = r0; v.l0 = l0; v.a0 = a0; v.ws0 = ws0;
        v.r1 = r1; v.l1 = l1; v.a1 = a1; v.ws1 = ws1; v.eg0 = eg0; v.eg1 = eg1;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] wd0_of(input logic [31:0] a);
        return 32'hCAFE_0000 ^ a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst      = v.rst;
        m0_req   = v.r0; m0_lock = v.l0; m0_addr = v.a0; m0_wsect = v.ws0; m0_wdata = wd0_of(v.a0);
        m1_req   = v.r1; m1_lock = v.l1; m1_addr = v.a1; m1_wsect = v.ws1; m1_wdata = 32'h0000_00AB;
    endtask

    task automatic check_cycle(input string tag, input vec_t v);
        rd_t e;
        if (v.rst) sb.delete();
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".m0_rvalid"}, m0_rvalid, e.id == 1'b0);
            chk({tag, ".m1_rvalid"}, m1_rvalid, e.id == 1'b1);
            chk({tag, ".m0_rdata"}, m0_rdata, (e.id == 1'b0) ? e.data : 32'h0);
            chk({tag, ".m1_rdata"}, m1_rdata, (e.id == 1'b1) ? e.data : 32'h0);
        end else begin
            chk({tag, ".m0_rvalid"}, m0_rvalid, 0);
            chk({tag, ".m1_rvalid"}, m1_rvalid, 0);
            chk({tag, ".m0_rdata"}, m0_rdata, 0);
            chk({tag, ".m1_rdata"}, m1_rdata, 0);
        end
        chk({tag, ".m0_gnt"}, m0_gnt, v.eg0);
        chk({tag, ".m1_gnt"}, m1_gnt, v.eg1);
        chk({tag, ".s_wsect"}, s_wsect, v.eg1 ? v.ws1 : (v.eg0 ? v.ws0 : 3'b000));
        chk({tag, ".s_wdata"}, s_wdata, v.eg1 ? 32'h0000_00AB : (v.eg0 ? wd0_of(v.a0) : 32'h0));
        chk({tag, ".s_addr"}, s_addr, v.eg1 ? v.a1 : v.a0);
        if (v.eg0 && v.ws0 == 3'b000) sb.push_back('{1'b0, mem_word(v.a0)});
        if (v.eg1 && v.ws1 == 3'b000) sb.push_back('{1'b1, mem_word(v.a1)});
    endtask

    task automatic step(input string tag, input vec_t v);
        @(posedge clk24);
        #1;
        drive(v);
        @(negedge clk24);
        check_cycle(tag, v);
    endtask

    initial begin
        vec_t v;
        //   rst r0 l0 a0         ws0     r1 l1 a1         ws1     eg0 eg1
        add(1, 1, 0, 32'h10,     3'b000, 1, 0, 32'h14,     3'b000, 0, 0); // reset, requests gated
        add(0, 0, 0, 32'h0,      3'b000, 0, 0, 32'h0,      3'b000, 0, 0);
        add(0, 1, 0, 32'h10,     3'b000, 0, 0, 32'h0,      3'b000, 1, 0); // m0 reads DEADBEEF
        add(0, 0, 0, 32'h0,      3'b000, 1, 0, 32'h30,     3'b000, 0, 1);
        add(0, 1, 0, 32'h40,     3'b000, 1, 0, 32'h44,     3'b000, 1, 0); // continuous tie
        add(0, 1, 0, 32'h48,     3'b000, 1, 0, 32'h44,     3'b000, 0, 1);
        add(0, 1, 0, 32'h4C,     3'b000, 1, 0, 32'h50,     3'b000, 1, 0);
        add(0, 1, 0, 32'h54,     3'b000, 1, 0, 32'h50,     3'b000, 0, 1);
        add(0, 1, 0, 32'h64,     3'b000, 1, 0, 32'h60,     3'b001, 1, 0); // m1 write waits
        add(0, 1, 0, 32'h68,     3'b100, 1, 0, 32'h60,     3'b001, 0, 1); // m1 write granted
        add(0, 1, 0, 32'h68,     3'b100, 0, 0, 32'h0,      3'b000, 1, 0);
        add(0, 0, 0, 32'h0,      3'b000, 0, 0, 32'h0,      3'b000, 0, 0);
        add(0, 0, 0, 32'h0,      3'b000, 1, 0, 32'h70,     3'b000, 0, 1); // last = m1
`ifdef MEM_ARB_LOCK_EN
        add(0, 1, 1, 32'h80,     3'b000, 1, 0, 32'h90,     3'b000, 1, 0); // lock holds 4 grants
        add(0, 1, 1, 32'h80,     3'b000, 1, 0, 32'h90,     3'b000, 1, 0);
        add(0, 1, 1, 32'h80,     3'b000, 1, 0, 32'h90,     3'b000, 1, 0);
        add(0, 1, 1, 32'h80,     3'b000, 1, 0, 32'h90,     3'b000, 1, 0);
        add(0, 1, 1, 32'h80,     3'b000, 1, 0, 32'h90,     3'b000, 0, 1); // forced release
`else
        add(0, 1, 1, 32'h80,     3'b000, 1, 0, 32'h90,     3'b000, 1, 0); // lock ignored
        add(0, 1, 1, 32'h80,     3'b000, 1, 0, 32'h90,     3'b000, 0, 1);
        add(0, 1, 1, 32'h80,     3'b000, 1, 0, 32'h90,     3'b000, 1, 0);
        add(0, 1, 1, 32'h80,     3'b000, 1, 0, 32'h90,     3'b000, 0, 1);
        add(0, 1, 1, 32'h80,     3'b000, 1, 0, 32'h90,     3'b000, 1, 0);
`endif
        add(0, 0, 0, 32'h0,      3'b000, 0, 0, 32'h0,      3'b000, 0, 0);
        add(0, 1, 1, 32'hA0,     3'b000, 0, 0, 32'h0,      3'b000, 1, 0); // m0 locks
`ifdef MEM_ARB_LOCK_EN
        add(0, 0, 0, 32'h0,      3'b000, 1, 0, 32'hB0,     3'b000, 0, 0); // m0 drops req: release
`else
        add(0, 0, 0, 32'h0,      3'b000, 1, 0, 32'hB0,     3'b000, 0, 1);
`endif
        add(0, 0, 0, 32'h0,      3'b000, 1, 0, 32'hB0,     3'b000, 0, 1);
        add(0, 0, 0, 32'h0,      3'b000, 0, 0, 32'h0,      3'b000, 0, 0);
        add(0, 0, 0, 32'h0,      3'b000, 1, 0, 32'hC0,     3'b000, 0, 1); // m1 read in flight
        add(1, 1, 0, 32'hD0,     3'b000, 1, 0, 32'hD4,     3'b000, 0, 0); // reset drops it
        add(0, 1, 0, 32'hD0,     3'b000, 1, 0, 32'hD4,     3'b000, 1, 0); // first tie to m0
        add(0, 0, 0, 32'h0,      3'b000, 1, 0, 32'hD4,     3'b000, 0, 1);
        add(0, 0, 0, 32'h0,      3'b000, 0, 0, 32'h0,      3'b000, 0, 0);

        foreach (vecs[i]) step($sformatf("v%0d", i), vecs[i]);

        // Reset raised exactly on the edge that would capture the read tag.
        v = vecs[0];
        v.rst = 0; v.r0 = 0; v.r1 = 1; v.a1 = 32'hE0; v.eg0 = 0; v.eg1 = 1;
        step("rsteg.accept", v);
        @(posedge clk24);
        rst = 1'b1;
        m1_req = 1'b0;
        #1;
        chk("rsteg.m1_rvalid_edge", m1_rvalid, 0);
        @(negedge clk24);
        sb.delete();
        chk("rsteg.m1_rvalid", m1_rvalid, 0);
        chk("rsteg.m1_rdata", m1_rdata, 0);
        chk("rsteg.m1_gnt", m1_gnt, 0);
        v.rst = 0; v.r1 = 0; v.eg1 = 0;
        step("rsteg.idle", v);
        v.r0 = 1; v.a0 = 32'hF0; v.r1 = 1; v.a1 = 32'hF4; v.eg0 = 1; v.eg1 = 0;
        step("rsteg.tie", v);
        v.r0 = 0; v.r1 = 0; v.eg0 = 0;
        step("rsteg.ret", v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the single data port of the block-RAM/memory-mapped-register subsystem between the core's data interface (master 0) and a second requester (master 1, e.g. program loader or debug port). It grants at most one access per cycle, round-robin, optionally holding the grant across locked sequences. It tags each accepted access so the one-cycle-latency read data is returned only to its issuer. It sits between `core` and the memory/MMIO decode in `top`.

## Interface
- `LOCK_MAX`, default 16: maximum consecutive grants one master may hold under lock before forced release.
- `clk24`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `m0_req`, `m1_req`  in  1  access request, held until granted.
- `m0_lock`, `m1_lock`  in  1  request that the grant be kept for the next access.
- `m0_addr`, `m1_addr`  in  32  byte address.
- `m0_wdata`, `m1_wdata`  in  32  unshifted write value.
- `m0_wsect`, `m1_wsect`  in  3  write sections: bit0 = byte 0, bit1 = byte 1, bit2 = upper halfword; 0 = read.
- `m0_gnt`, `m1_gnt`  out  1  combinational; access accepted this cycle when req && gnt.
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid for an access accepted the previous cycle.
- `m0_rdata`, `m1_rdata`  out  32  read data, passed from `s_rdata`.
- `s_addr`  out  32  address to memory/MMIO decode.
- `s_wdata`  out  32  write value to memory/MMIO decode.
- `s_wsect`  out  3  write sections; forced 0 when no grant.
- `s_rdata`  in  32  read data, valid one cycle after address presented.

## Operation
- Owner FSM states: `IDLE` (no lock held), `OWN0`, `OWN1`. Register `last` (winner of last unlocked arbitration) and lock counter `lock_cnt` (width clog2(LOCK_MAX+1)).
- `IDLE`: if only one master requests, grant it. If both request, grant the master that is not `last`. Grant updates `last`. If the granted master has lock=1, go to `OWN<n>` with `lock_cnt`=1.
- `OWN<n>`: only master n may be granted; the other's gnt = 0. On a granted access with lock=1 and `lock_cnt` < LOCK_MAX, stay and increment. Return to `IDLE` on any of the following:
  - granted access with lock=0;
  - `lock_cnt` == LOCK_MAX (the access is still granted);
  - a cycle where master n has req=0.
  The other master is not granted in that same cycle.
- Slave port is muxed from the granted master. With no grant: `s_addr` = m0_addr, `s_wdata` = 0, `s_wsect` = 0. Any request from an ungranted master never reaches the slave.
- Read tag: registers `rv0`/`rv1` are set to (gnt_n && req_n && wsect_n == 0) each cycle. `mN_rvalid` = `rvN`. `mN_rdata` = `s_rdata` when `rvN`, else 0.
- Writes produce no rvalid.
- Requests are not queued; the master holds req/addr/wdata/wsect stable until granted.

## Timing
- Grant: combinational from req, lock, and state; zero-cycle decision.
- Read latency: accept in cycle N, rvalid and rdata in cycle N+1. Back-to-back reads give 1 per cycle.
- Reset values while `rst` is high:
  - state = `IDLE`, `last` = 1 (so master 0 wins the first tie), `lock_cnt` = 0, rv0 = rv1 = 0;
  - both gnt = 0, `s_wsect` = 0, both rvalid = 0, both rdata = 0.
- Reset asserted with a read in flight: the rvalid is dropped and never appears.
- Under simultaneous requests in `IDLE`, grants alternate every cycle.
- `lock_cnt` never wraps; it saturates at LOCK_MAX and release is forced.

## Configuration
- `MEM_ARB_LOCK_EN` defined: lock behaviour as above.
- `MEM_ARB_LOCK_EN` undefined:
  - `mN_lock` inputs are ignored;
  - the FSM stays in `IDLE` permanently and `lock_cnt` is not built;
  - pure per-cycle round-robin.

## Structure
- Package `mem_arb_pkg` holds:
  - section-mask constants `SECT_BYTE0`=3'b001, `SECT_BYTE1`=3'b010, `SECT_HALF_HI`=3'b100, `SECT_WORD`=3'b111;
  - owner-state enum (`IDLE`, `OWN0`, `OWN1`).
- One sub-module, `mem_arb_rr_pick`: combinational two-way round-robin pick from (req0, req1, last) producing one-hot grant. Used only in `IDLE`.

## Test plan
- Reset, then m0 reads 0x00000010 alone; RAM word = 0xDEADBEEF -> m0_gnt=1 same cycle, m0_rvalid=1 with m0_rdata=0xDEADBEEF next cycle, m1_rvalid=0.
- Both masters request reads continuously for 4 cycles -> grants m0,m1,m0,m1; each rvalid one cycle after its grant with the correct word.
- m1 writes 0x000000AB with wsect=001 while m0 also requests -> exactly one is granted per cycle; the ungranted master's wsect never appears on `s_wsect`; no rvalid for the write.
- (`MEM_ARB_LOCK_EN`, LOCK_MAX=4) m0 holds lock=1 with m1 requesting -> m0 granted 4 consecutive cycles, then m1 granted in the 5th.
- m0 locks, then drops req for one cycle -> FSM returns to `IDLE`; m1 granted in the following cycle.
- Assert `rst` in the cycle after m1 read accept -> m1_rvalid stays 0; after release, the first tie goes to m0.
